// File: rtl/axi_burst_rom_responder_if.sv
// AXI4 read-address / read-data channel bundle for axi_burst_rom_responder.
// The master modport is the fetch initiator; the slave modport is the ROM responder.
interface axi_burst_rom_responder_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rlast;

  modport master (
    output araddr, arvalid, arlen, arburst, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  araddr, arvalid, arlen, arburst, rready,
    output arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/axi_burst_rom_responder.sv
// AXI4 read-only burst responder backed by a preloadable word array, with a
// configurable first-beat latency. Define AXI_BURST_ROM_STALL_EN for LFSR-driven inter-beat gaps.
module axi_burst_rom_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH_DIG = 10,
  parameter int          LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_burst_rom_responder_if.slave bus,
  input  logic                 ld_we,
  input  logic [DEPTH_DIG-1:0] ld_addr,
  input  logic [31:0]          ld_wdata
);

  localparam logic [29:0] BASE_WORD   = ADDR_BASE[31:2];
  localparam logic [3:0]  LAT_LAST    = 4'(LATENCY - 1);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    BEAT,
    GAP
  } state_t;

  logic [31:0] mem [2**DEPTH_DIG];

  state_t      state;
  logic [29:0] beat_addr;
  logic [7:0]  beat_cnt;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic [3:0]  lat_cnt;

  logic [29:0] next_addr;
  logic [29:0] load_addr;
  logic [7:0]  load_cnt;
  logic [7:0]  load_len;
  logic [1:0]  load_burst;
  logic [29:0] load_off;
  logic        load_ok;
  logic [31:0] load_data;
  logic [1:0]  load_resp;
  logic        load_last;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.araddr[1:0];

`ifdef AXI_BURST_ROM_STALL_EN
  logic [7:0] lfsr;
  logic [1:0] gap_cnt;
  logic       lfsr_fb;
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
`endif

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_wdata;
    end
  end

  assign next_addr = (burst_q == BURST_INCR) ? beat_addr + 30'd1 : beat_addr;

  // The beat to load depends on where it is loaded from: the AR channel itself
  // (zero latency), the post-handshake next beat, or the already-advanced registers.
  always_comb begin
    load_addr  = beat_addr;
    load_cnt   = beat_cnt;
    load_len   = len_q;
    load_burst = burst_q;
    if (state == IDLE) begin
      load_addr  = bus.araddr[31:2];
      load_cnt   = '0;
      load_len   = bus.arlen;
      load_burst = bus.arburst;
    end else if (state == BEAT) begin
      load_addr = next_addr;
      load_cnt  = beat_cnt + 8'd1;
    end
  end

  assign load_off  = load_addr - BASE_WORD;
  assign load_ok   = ((load_burst == BURST_FIXED) || (load_burst == BURST_INCR)) &&
                     (load_off[29:DEPTH_DIG] == '0);
  assign load_data = load_ok ? mem[load_off[DEPTH_DIG-1:0]] : 32'd0;
  assign load_resp = load_ok ? RESP_OKAY : RESP_SLVERR;
  assign load_last = (load_cnt == load_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.arready   <= 1'b1;
      bus.rvalid    <= 1'b0;
      bus.rlast     <= 1'b0;
      bus.rdata     <= '0;
      bus.rresp     <= RESP_OKAY;
      beat_addr     <= '0;
      beat_cnt      <= '0;
      len_q         <= '0;
      burst_q       <= BURST_FIXED;
      lat_cnt       <= '0;
`ifdef AXI_BURST_ROM_STALL_EN
      lfsr          <= 8'hA5;
      gap_cnt       <= '0;
`endif
    end else begin
`ifdef AXI_BURST_ROM_STALL_EN
      lfsr <= {lfsr[6:0], lfsr_fb};
`endif
      case (state)
        IDLE: begin
          if (bus.arvalid && bus.arready) begin
            beat_addr   <= bus.araddr[31:2];
            len_q       <= bus.arlen;
            burst_q     <= bus.arburst;
            beat_cnt    <= '0;
            lat_cnt     <= '0;
            bus.arready <= 1'b0;
            if (LATENCY == 0) begin
              bus.rdata  <= load_data;
              bus.rresp  <= load_resp;
              bus.rlast  <= load_last;
              bus.rvalid <= 1'b1;
              state      <= BEAT;
            end else begin
              state <= LAT;
            end
          end
        end

        LAT: begin
          if (lat_cnt == LAT_LAST) begin
            bus.rdata  <= load_data;
            bus.rresp  <= load_resp;
            bus.rlast  <= load_last;
            bus.rvalid <= 1'b1;
            state      <= BEAT;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end

        // Beat registers advance on every non-last handshake so a gap can
        // later reload the next beat from them unchanged.
        BEAT: begin
          if (bus.rready) begin
            if (bus.rlast) begin
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.arready <= 1'b1;
              state       <= IDLE;
            end else begin
              beat_addr <= next_addr;
              beat_cnt  <= beat_cnt + 8'd1;
`ifdef AXI_BURST_ROM_STALL_EN
              if (lfsr[1:0] == 2'b00) begin
                bus.rvalid <= 1'b0;
                gap_cnt    <= lfsr[3:2];
                state      <= GAP;
              end else begin
                bus.rdata <= load_data;
                bus.rresp <= load_resp;
                bus.rlast <= load_last;
              end
`else
              bus.rdata <= load_data;
              bus.rresp <= load_resp;
              bus.rlast <= load_last;
`endif
            end
          end
        end

        GAP: begin
`ifdef AXI_BURST_ROM_STALL_EN
          if (gap_cnt == 2'd0) begin
            bus.rdata  <= load_data;
            bus.rresp  <= load_resp;
            bus.rlast  <= load_last;
            bus.rvalid <= 1'b1;
            state      <= BEAT;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_rom_responder.sv
// Scoreboard testbench for axi_burst_rom_responder: expected beats are queued
// from a shadow memory when a burst is issued and compared as the DUT returns them.
module tb_axi_burst_rom_responder;

   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int          DEPTH_DIG = 10;
   localparam int          LATENCY   = 2;
   localparam int          DEPTH     = 2**DEPTH_DIG;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ld_we;
   logic [DEPTH_DIG-1:0] ld_addr;
   logic [31:0]          ld_wdata;

   axi_burst_rom_responder_if bus();

   beat_t       sb[$];
   logic [31:0] tb_mem [DEPTH];
   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cyc_cnt      = 0;
   int          rready_mode  = 0;
   int          rready_pat   = 0;
   bit          b2b_check    = 1'b0;
   bit          have_prev    = 1'b0;
   int          prev_cyc     = 0;

   always #5 clk = ~clk;

   axi_burst_rom_responder #(
      .ADDR_BASE (BASE),
      .DEPTH_DIG (DEPTH_DIG),
      .LATENCY   (LATENCY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_wdata (ld_wdata)
   );

   // Counts every comparison and reports any mismatch on a single line.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // rready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = never ready.
   initial begin
      bus.rready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rready_mode)
            0: bus.rready = 1'b1;
            1: begin
               bus.rready = (rready_pat % 3 == 0);
               rready_pat++;
            end
            default: bus.rready = 1'b0;
         endcase
      end
   end

   // Compares each beat that will handshake at the coming edge against the
   // scoreboard head; while stalled, the presented beat must stay equal to it.
   always @(negedge clk) begin : monitor
      beat_t e;
      if (!rst && bus.rvalid) begin
         if (bus.rready) begin
            if (sb.size() == 0) begin
               checkOutput("extra_beat", {31'd0, bus.rvalid}, 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("rdata", bus.rdata, e.data);
               checkOutput("rresp", {30'd0, bus.rresp}, {30'd0, e.resp});
               checkOutput("rlast", {31'd0, bus.rlast}, {31'd0, e.last});
               if (b2b_check && have_prev)
                  checkOutput("b2b_gap", cyc_cnt - prev_cyc, 32'd1);
               prev_cyc  = cyc_cnt;
               have_prev = 1'b1;
            end
         end else if (sb.size() > 0) begin
            checkOutput("hold_rdata", bus.rdata, sb[0].data);
            checkOutput("hold_rlast", {31'd0, bus.rlast}, {31'd0, sb[0].last});
         end
      end
   end

   task automatic loadWord(input int idx, input logic [31:0] d);
      ld_we    = 1'b1;
      ld_addr  = idx[DEPTH_DIG-1:0];
      ld_wdata = d;
      @(posedge clk);
      #1;
      ld_we       = 1'b0;
      tb_mem[idx] = d;
   endtask

   task automatic pushExpected(input logic [31:0] addr, input int len, input logic [1:0] burst);
      logic [29:0] w;
      logic [29:0] off;
      logic [29:0] base_w;
      bit          ok;
      beat_t       e;
      base_w = BASE[31:2];
      for (int i = 0; i <= len; i++) begin
         w      = addr[31:2] + ((burst == 2'b01) ? 30'(i) : 30'd0);
         off    = w - base_w;
         ok     = (burst == 2'b00 || burst == 2'b01) && (int'(off) < DEPTH) && (off < 30'(DEPTH));
         e.data = ok ? tb_mem[int'(off)] : 32'd0;
         e.resp = ok ? 2'b00 : 2'b10;
         e.last = (i == len);
         sb.push_back(e);
      end
   endtask

   task automatic issueAr(input logic [31:0] addr, input int len, input logic [1:0] burst);
      bit ok;
      int cyc;
      bus.araddr  = addr;
      bus.arlen   = len[7:0];
      bus.arburst = burst;
      bus.arvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.arready) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("ar_accept", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) checkOutput("arready_busy", {31'd0, bus.arready}, 32'd0);
         if (bus.rvalid) break;
      end
      checkOutput("first_latency", cyc, LATENCY + 1);
   endtask

   task automatic waitDone();
      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
      checkOutput("burst_done", sb.size(), 32'd0);
      @(negedge clk);
      checkOutput("arready_after", {31'd0, bus.arready}, 32'd1);
      checkOutput("rvalid_after", {31'd0, bus.rvalid}, 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input int len, input logic [1:0] burst);
      pushExpected(addr, len, burst);
      issueAr(addr, len, burst);
      waitDone();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst         = 1'b1;
      ld_we       = 1'b0;
      ld_addr     = '0;
      ld_wdata    = '0;
      bus.araddr  = '0;
      bus.arlen   = '0;
      bus.arburst = 2'b01;
      bus.arvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
      checkOutput("reset_rlast", {31'd0, bus.rlast}, 32'd0);
      checkOutput("reset_rdata", bus.rdata, 32'd0);
      checkOutput("reset_rresp", {30'd0, bus.rresp}, 32'd0);
      checkOutput("reset_arready", {31'd0, bus.arready}, 32'd1);
      @(posedge clk);
      #1;

      // Basic INCR burst, back-to-back beats
      loadWord(0, 32'h11);
      loadWord(1, 32'h22);
      loadWord(2, 32'h33);
      loadWord(3, 32'h44);
`ifdef AXI_BURST_ROM_STALL_EN
      b2b_check = 1'b0;
`else
      b2b_check = 1'b1;
`endif
      have_prev = 1'b0;
      applyStimulus(BASE, 3, 2'b01);
      b2b_check = 1'b0;

      // Backpressure 1,0,0,...
      rready_mode = 1;
      rready_pat  = 0;
      applyStimulus(BASE, 3, 2'b01);
      rready_mode = 0;

      // Crossing the top of memory
      loadWord(DEPTH - 2, 32'hCAFE_0001);
      loadWord(DEPTH - 1, 32'hCAFE_0002);
      applyStimulus(BASE + 32'(4 * (DEPTH - 2)), 3, 2'b01);

      // FIXED burst and unsupported burst types
      loadWord(2, 32'hDEAD_BEEF);
      applyStimulus(BASE + 32'h8, 2, 2'b00);
      applyStimulus(BASE, 1, 2'b10);
      applyStimulus(BASE + 32'h4, 2, 2'b11);

      // Single beat, below-base address, full 256-beat burst
      applyStimulus(BASE + 32'h4, 0, 2'b01);
      applyStimulus(32'h0000_0010, 0, 2'b01);
      for (int i = 0; i < 256; i++) loadWord(i, 32'hA000_0000 + 32'(i * 3));
      applyStimulus(BASE, 255, 2'b01);

      // Reset while the second beat is being held
      pushExpected(BASE, 3, 2'b01);
      issueAr(BASE, 3, 2'b01);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (sb.size() == 3) break;
      end
      rready_mode = 2;
      checkOutput("pre_reset_popped", sb.size(), 32'd3);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
      checkOutput("midrst_arready", {31'd0, bus.arready}, 32'd1);
      checkOutput("midrst_rlast", {31'd0, bus.rlast}, 32'd0);
      rready_mode = 0;
      @(posedge clk);
      #1;
      applyStimulus(BASE + 32'h10, 3, 2'b01);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axi_burst_rom_responder.md
Name: axi_burst_rom_responder

Overview:
- AXI4 read-only burst responder: the memory-side end of the instruction-fetch path, answering the INCR burst requests issued by the instruction cache on miss.
- Backed by an internal word array, filled through a simple preload port (bench or boot loader).
- Models a configurable first-beat latency.
- Returns SLVERR for out-of-range or unsupported bursts while still honouring the requested beat count.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_DIG, 10, memory depth = 2^DEPTH_DIG 32-bit words.
- LATENCY, 2, idle cycles between AR handshake and first rvalid (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- araddr  in  32  burst start byte address; bits [1:0] ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arlen  in  8  beats minus one
- arburst  in  2  burst type (00 FIXED, 01 INCR, others unsupported)
- rdata  out  32  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rlast  out  1  final beat of burst
- ld_we  in  1  preload write enable
- ld_addr  in  DEPTH_DIG  preload word index
- ld_wdata  in  32  preload data

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Memory contents are not reset.
- Reset values: rvalid=0, rlast=0, rdata=0, rresp=00, state=IDLE. arready=1 from the first cycle after reset.
- arready = (state==IDLE). Only one burst is outstanding; no AR pipelining.
- States:
  - IDLE: on arvalid&&arready, latch araddr[31:2], arlen, arburst; clear beat_cnt and lat_cnt. Go to LAT if LATENCY>0, else load beat 0 and go to BEAT.
  - LAT: lat_cnt increments each cycle. When lat_cnt==LATENCY-1, load beat 0 and go to BEAT. Minimum AR-handshake-to-rvalid = LATENCY+1 cycles.
  - BEAT: rvalid=1. rdata, rresp and rlast are registered and stay stable until rvalid&&rready. On handshake:
    - if rlast: go to IDLE; rvalid=0 next cycle; arready=1 next cycle.
    - else: beat_cnt+1, compute next address, load next beat in the same edge; rvalid stays 1, so back-to-back beats run at 1 beat/cycle.
- Beat load:
  - word offset = beat_addr - ADDR_BASE[31:2], 30-bit unsigned, wraps.
  - In range if offset < 2^DEPTH_DIG: rdata = mem[offset[DEPTH_DIG-1:0]], rresp = 00.
  - Otherwise rdata = 0, rresp = 10.
  - rlast = (beat_cnt == arlen latched).
- Next-beat address: INCR adds 1 word per beat, 30-bit wrap, range checked per beat; a burst crossing the top of memory gets OKAY then SLVERR beats. FIXED reuses the same word. arburst 10/11 gives SLVERR on every beat, rdata 0, still arlen+1 beats with correct rlast.
- arlen=0: single beat, rlast=1.
- arlen=255: 256 beats. beat_cnt is 8-bit and never overflows.
- Preload: on ld_we, mem[ld_addr] <= ld_wdata at the edge. Allowed in any state. A write to a word already loaded into rdata does not change the beat in flight. Beats loaded after the write see the new value.
- rst mid-burst: state→IDLE, rvalid=0 at that edge; the burst is abandoned and no rlast is issued.
- arvalid while not IDLE: ignored (arready=0); the request must be held by the initiator.

Optional Feature:
- Macro AXI_BURST_ROM_STALL_EN.
- Defined:
  - 8-bit LFSR, x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst, advances every cycle.
  - After each non-last beat handshake, when LFSR[1:0]==2'b00 the block drops rvalid for LFSR[3:2]+1 cycles before presenting the next beat.
  - Data, order, rresp and rlast are unchanged.
- Undefined: no LFSR, no inter-beat gaps; behaviour exactly as above.

Test Plan:
1. Preload mem[0..3]=32'h11,22,33,44. AR araddr=32'h8000_0000, arlen=3, INCR, rready=1 → rvalid first seen 3 cycles after AR handshake; rdata 11,22,33,44 on consecutive cycles, rresp=00, rlast only on 44; arready=1 the cycle after the last beat.
2. Same burst with rready toggling 1,0,0,1,... → each beat's rdata/rlast held while rready=0; no beat lost or duplicated.
3. araddr=ADDR_BASE+4*(2^DEPTH_DIG-2), arlen=3, INCR → beats OKAY, OKAY, SLVERR(rdata 0), SLVERR(rdata 0); rlast on the 4th beat.
4. FIXED, araddr=32'h8000_0008, arlen=2, mem[2]=32'hDEAD_BEEF → three beats of DEAD_BEEF, rlast on the 3rd. arburst=2'b10, arlen=1 → two SLVERR beats with rlast on the 2nd.
5. arlen=0 → single beat with rlast=1. arlen=255 INCR from base → 256 beats, rlast only on beat 255, data matches mem[0..255].
6. rst asserted during beat 2 of a 4-beat burst → rvalid=0 and arready=1 the cycle after the reset edge; a new burst then completes normally with LATENCY intact.
